floor_request_servicer: RTL and testbench

- Consumer side of the per-floor request latches in the elevator datapath.
- Reads the latched call vector each cycle and decides car motion using a SCAN policy: keep going in the current direction while requests remain that way.
- Tracks the current floor with a travel timer and runs the door interval.
- Returns a one-cycle served strobe that clears the request latch of the floor just serviced.

---
 rtl/elev_pkg.sv | 17 +
 rtl/cycle_timer.sv | 44 ++++
 rtl/floor_request_servicer.sv | 224 ++++++++++++++++++++++
 tb/tb_floor_request_servicer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elev_pkg.sv
// Shared elevator definitions: servicer state encoding and default
// geometry/timing constants (also used by the request-latch bank).
package elev_pkg;

    localparam int unsigned FLOORS_DFLT     = 8;
    localparam int unsigned FLOOR_W_DFLT    = 3;
    localparam int unsigned TRAVEL_CYC_DFLT = 4;
    localparam int unsigned DOOR_CYC_DFLT   = 6;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR      = 2'd3
    } svc_state_e;

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter shared by the travel and door intervals.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load_i       load load_val_i (wins over hold)
//   load_val_i   value loaded; interval lasts load_val_i+1 cycles
//   hold_i       freeze the count
//   expired_o    registered flag, high while the count is zero
module cycle_timer #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         hold_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         expired_q;

    // Count down to zero and park there until the next load.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (!hold_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            expired_q <= 1'b1;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= (cnt_d == '0);
        end
    end

    assign expired_o = expired_q;

endmodule

// File: rtl/floor_request_servicer.sv
// SCAN-policy elevator servicer: reads the latched call vector, moves the
// car floor by floor, runs the door interval and strobes served[f] to clear
// the request latch of the floor just serviced.
// Optional macro SVC_DOOR_HOLD_EN adds door_hold, which freezes the door
// timer while the door is open.
// Ports:
//   clk, clr_n   clock, asynchronous active-low reset
//   req          latched floor calls
//   door_hold    (SVC_DOOR_HOLD_EN only) keep the door open
//   served       one-cycle one-hot clear strobe
//   cur_floor    current floor
//   dir_up       preferred/current direction
//   moving       travelling between floors
//   door_open    door open
//   busy         not idle
module floor_request_servicer
    import elev_pkg::*;
#(
    parameter int unsigned FLOORS     = FLOORS_DFLT,
    parameter int unsigned FLOOR_W    = FLOOR_W_DFLT,
    parameter int unsigned TRAVEL_CYC = TRAVEL_CYC_DFLT,
    parameter int unsigned DOOR_CYC   = DOOR_CYC_DFLT
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic [FLOORS-1:0]  req,
`ifdef SVC_DOOR_HOLD_EN
    input  logic               door_hold,
`endif
    output logic [FLOORS-1:0]  served,
    output logic [FLOOR_W-1:0] cur_floor,
    output logic               dir_up,
    output logic               moving,
    output logic               door_open,
    output logic               busy
);

    localparam int unsigned MAX_CYC = (TRAVEL_CYC > DOOR_CYC) ? TRAVEL_CYC : DOOR_CYC;
    localparam int unsigned TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [TMR_W-1:0] TRAVEL_LD = TMR_W'(TRAVEL_CYC - 1);
    localparam logic [TMR_W-1:0] DOOR_LD   = TMR_W'(DOOR_CYC - 1);

    // Any call strictly above floor f.
    function automatic logic any_above(input logic [FLOORS-1:0] r,
                                       input logic [FLOOR_W-1:0] f);
        any_above = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (i > int'(f)) any_above = any_above | r[i];
        end
    endfunction

    // Any call strictly below floor f.
    function automatic logic any_below(input logic [FLOORS-1:0] r,
                                       input logic [FLOOR_W-1:0] f);
        any_below = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (i < int'(f)) any_below = any_below | r[i];
        end
    endfunction

    function automatic logic [FLOORS-1:0] onehot(input logic [FLOOR_W-1:0] f);
        onehot    = '0;
        onehot[f] = 1'b1;
    endfunction

    // SCAN choice ignoring the current floor; dir_up breaks the tie.
    function automatic svc_state_e pick_next(input logic up, input logic ab, input logic bl);
        if (ab && (up || !bl)) begin
            pick_next = MOVE_UP;
        end else if (bl) begin
            pick_next = MOVE_DOWN;
        end else begin
            pick_next = IDLE;
        end
    endfunction

    svc_state_e         state_q, state_d;
    logic [FLOOR_W-1:0] floor_q, floor_d;
    logic               dir_q, dir_d;
    logic [FLOORS-1:0]  served_q, served_d;
    logic               moving_q, door_q, busy_q;

    logic [FLOOR_W-1:0] floor_up, floor_dn, door_fl;
    logic               above_cur, below_cur, above_up, below_up, above_dn, below_dn;
    logic               tmr_load, tmr_exp, hold_c, take_pick, enter_door;
    logic [TMR_W-1:0]   tmr_val;
    svc_state_e         pick_sel;

    assign floor_up  = floor_q + FLOOR_W'(1);
    assign floor_dn  = floor_q - FLOOR_W'(1);
    assign above_cur = any_above(req, floor_q);
    assign below_cur = any_below(req, floor_q);
    assign above_up  = any_above(req, floor_up);
    assign below_up  = any_below(req, floor_up);
    assign above_dn  = any_above(req, floor_dn);
    assign below_dn  = any_below(req, floor_dn);

`ifdef SVC_DOOR_HOLD_EN
    assign hold_c = door_hold && (state_q == DOOR);
`else
    assign hold_c = 1'b0;
`endif

    cycle_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (clr_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .hold_i     (hold_c),
        .expired_o  (tmr_exp)
    );

    // Next-state, floor, direction, served strobe and timer control.
    always_comb begin
        state_d    = state_q;
        floor_d    = floor_q;
        dir_d      = dir_q;
        served_d   = '0;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        take_pick  = 1'b0;
        pick_sel   = IDLE;
        enter_door = 1'b0;
        door_fl    = floor_q;

        case (state_q)
            IDLE: begin
                if (req[floor_q]) begin
                    enter_door = 1'b1;
                end else begin
                    take_pick = 1'b1;
                    pick_sel  = pick_next(dir_q, above_cur, below_cur);
                end
            end
            MOVE_UP: begin
                // Arrival decision uses the floor being entered.
                if (tmr_exp) begin
                    floor_d = floor_up;
                    door_fl = floor_up;
                    if (req[floor_up]) begin
                        enter_door = 1'b1;
                    end else begin
                        take_pick = 1'b1;
                        pick_sel  = pick_next(dir_q, above_up, below_up);
                    end
                end
            end
            MOVE_DOWN: begin
                if (tmr_exp) begin
                    floor_d = floor_dn;
                    door_fl = floor_dn;
                    if (req[floor_dn]) begin
                        enter_door = 1'b1;
                    end else begin
                        take_pick = 1'b1;
                        pick_sel  = pick_next(dir_q, above_dn, below_dn);
                    end
                end
            end
            DOOR: begin
                // While served is pulsing the latch still shows the old call.
                if (req[floor_q] && !(|served_q)) begin
                    enter_door = 1'b1;
                end else if (tmr_exp && !hold_c) begin
                    take_pick = 1'b1;
                    pick_sel  = pick_next(dir_q, above_cur, below_cur);
                end
            end
            default: state_d = IDLE;
        endcase

        // Door entry and re-call share the strobe and the interval restart.
        if (enter_door) begin
            state_d  = DOOR;
            served_d = onehot(door_fl);
            tmr_load = 1'b1;
            tmr_val  = DOOR_LD;
        end

        if (take_pick) begin
            state_d = pick_sel;
            if (pick_sel == MOVE_UP) begin
                dir_d = 1'b1;
            end else if (pick_sel == MOVE_DOWN) begin
                dir_d = 1'b0;
            end
            if (pick_sel != IDLE) begin
                tmr_load = 1'b1;
                tmr_val  = TRAVEL_LD;
            end
        end
    end

    // State and registered status outputs.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= IDLE;
            floor_q  <= '0;
            dir_q    <= 1'b1;
            served_q <= '0;
            moving_q <= 1'b0;
            door_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            floor_q  <= floor_d;
            dir_q    <= dir_d;
            served_q <= served_d;
            moving_q <= (state_d == MOVE_UP) || (state_d == MOVE_DOWN);
            door_q   <= (state_d == DOOR);
            busy_q   <= (state_d != IDLE);
        end
    end

    assign served    = served_q;
    assign cur_floor = floor_q;
    assign dir_up    = dir_q;
    assign moving    = moving_q;
    assign door_open = door_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_floor_request_servicer.sv
// Bench for floor_request_servicer: a behavioural car model plus a model of
// the request-latch bank, compared against the DUT every cycle.
module tb_floor_request_servicer;

    localparam int TRAVEL = 4;
    localparam int DOORC  = 6;
    localparam logic [14:0] RST_OBS = {8'h00, 3'd0, 1'b1, 3'b000};

    logic       clk = 1'b0;
    logic       clr_n;
    logic [7:0] req;
    logic       hold_drv;
    logic [7:0] served;
    logic [2:0] cur_floor;
    logic       dir_up, moving, door_open, busy;
    logic [14:0] obs;

    always #5 clk = ~clk;

    floor_request_servicer #(
        .FLOORS     (8),
        .FLOOR_W    (3),
        .TRAVEL_CYC (TRAVEL),
        .DOOR_CYC   (DOORC)
    ) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .req       (req),
`ifdef SVC_DOOR_HOLD_EN
        .door_hold (hold_drv),
`endif
        .served    (served),
        .cur_floor (cur_floor),
        .dir_up    (dir_up),
        .moving    (moving),
        .door_open (door_open),
        .busy      (busy)
    );

    assign obs = {served, cur_floor, dir_up, moving, door_open, busy};

    int errors = 0;
    int checks = 0;

    // Car model: mode 0 idle, 1 up, 2 down, 3 door; m_left = cycles left in interval.
    int         m_mode, m_floor, m_left;
    bit         m_up;
    logic [7:0] m_served;
    logic [7:0] r;

    function automatic bit has_above(logic [7:0] v, int f);
        return (v >> (f + 1)) != 0;
    endfunction

    function automatic bit has_below(logic [7:0] v, int f);
        return (v & ((8'd1 << f) - 8'd1)) != 0;
    endfunction

    function automatic logic [14:0] m_obs();
        return {m_served, 3'(m_floor), m_up, (m_mode == 1) || (m_mode == 2),
                m_mode == 3, m_mode != 0};
    endfunction

    task automatic m_reset();
        m_mode = 0; m_floor = 0; m_up = 1'b1; m_left = 0; m_served = '0;
        r = '0; req = '0;
    endtask

    task automatic m_enter_door();
        m_mode = 3; m_left = DOORC; m_served = 8'd1 << m_floor;
    endtask

    task automatic m_choose(input logic [7:0] v);
        bit a, b;
        a = has_above(v, m_floor);
        b = has_below(v, m_floor);
        if (m_up) begin
            if (a) m_mode = 1;
            else if (b) begin m_mode = 2; m_up = 1'b0; end
            else m_mode = 0;
        end else begin
            if (b) m_mode = 2;
            else if (a) begin m_mode = 1; m_up = 1'b1; end
            else m_mode = 0;
        end
        if (m_mode != 0) m_left = TRAVEL;
    endtask

    task automatic m_step(input logic [7:0] v, input bit hold);
        logic [7:0] prev = m_served;
        m_served = '0;
        if (m_mode == 0) begin
            if (v[m_floor]) m_enter_door(); else m_choose(v);
        end else if (m_mode == 1 || m_mode == 2) begin
            m_left--;
            if (m_left == 0) begin
                m_floor += (m_mode == 1) ? 1 : -1;
                if (v[m_floor]) m_enter_door(); else m_choose(v);
            end
        end else begin
            if (v[m_floor] && prev == 0) begin
                m_served = 8'd1 << m_floor;
                m_left = DOORC;
            end else if (!hold) begin
                m_left--;
                if (m_left == 0) m_choose(v);
            end
        end
    endtask

    // One clock: advance the model on the cycle just ended, then update the latch.
    task automatic tick(input logic [7:0] calls, input bit hold_next);
        logic [7:0] prev_served;
        bit hold_cur;
        @(posedge clk);
        #1;
        prev_served = m_served;
`ifdef SVC_DOOR_HOLD_EN
        hold_cur = hold_drv;
`else
        hold_cur = 1'b0;
`endif
        m_step(r, hold_cur);
        r = (r & ~prev_served) | calls;
        req = r;
        hold_drv = hold_next;
    endtask

    task automatic test_reset();
        #2 clr_n = 1'b0;
        #1;
        if (obs !== RST_OBS) begin errors++; $display("FAIL reset_power got=%h exp=%h", obs, RST_OBS); end
        checks++;
        @(negedge clk) clr_n = 1'b1;
        tick(8'h40, 1'b0);
        for (int i = 0; i < 7; i++) begin
            tick(8'h00, 1'b0);
            if (obs !== m_obs()) begin errors++; $display("FAIL reset_run t=%0t got=%h exp=%h", $time, obs, m_obs()); end
            checks++;
        end
        // Abort mid-move, between clock edges.
        #2 clr_n = 1'b0;
        #1;
        if (obs !== RST_OBS) begin errors++; $display("FAIL reset_midmove got=%h exp=%h", obs, RST_OBS); end
        checks++;
        m_reset();
        @(negedge clk) clr_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(8'h00, 1'b0);
            if (obs !== m_obs() || busy !== 1'b0) begin errors++; $display("FAIL reset_idle t=%0t got=%h exp=%h", $time, obs, m_obs()); end
            checks++;
        end
    endtask

    task automatic test_move_up();
        int mv = 0, dr = 0, sv = 0, trace = 0, last = 0;
        bit done = 0;
        tick(8'h08, 1'b0);
        for (int i = 0; i < 40 && !done; i++) begin
            tick(8'h00, 1'b0);
            if (obs !== m_obs()) begin errors++; $display("FAIL move_up t=%0t got=%h exp=%h", $time, obs, m_obs()); end
            checks++;
            if (moving === 1'b1) mv++;
            if (door_open === 1'b1) dr++;
            if (served === 8'h08) sv++;
            if (int'(cur_floor) != last) begin trace = trace * 10 + int'(cur_floor); last = int'(cur_floor); end
            if (m_mode == 0) done = 1;
        end
        if (!done) begin errors++; $display("FAIL move_up_timeout got=busy exp=idle"); end
        checks++;
        if (mv != 12) begin errors++; $display("FAIL move_up_moving got=%0d exp=12", mv); end
        checks++;
        if (dr != 6) begin errors++; $display("FAIL move_up_door got=%0d exp=6", dr); end
        checks++;
        if (sv != 1) begin errors++; $display("FAIL move_up_served got=%0d exp=1", sv); end
        checks++;
        if (trace != 123 || cur_floor !== 3'd3) begin errors++; $display("FAIL move_up_floors got=%0d/%0d exp=123/3", trace, cur_floor); end
        checks++;
    endtask

    task automatic test_idle_here();
        int mv = 0, dr = 0, sv = 0, first = -1;
        bit done = 0;
        tick(8'h04, 1'b0);
        for (int i = 0; i < 60 && !done; i++) begin
            tick(8'h00, 1'b0);
            if (obs !== m_obs()) begin errors++; $display("FAIL idle_setup t=%0t got=%h exp=%h", $time, obs, m_obs()); end
            checks++;
            if (m_mode == 0) done = 1;
        end
        if (!done || cur_floor !== 3'd2) begin errors++; $display("FAIL idle_setup_floor got=%0d exp=2", cur_floor); end
        checks++;
        tick(8'h04, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick(8'h00, 1'b0);
            if (obs !== m_obs()) begin errors++; $display("FAIL idle_here t=%0t got=%h exp=%h", $time, obs, m_obs()); end
            checks++;
            if (moving === 1'b1) mv++;
            if (door_open === 1'b1) begin dr++; if (first < 0) first = i; end
            if (served === 8'h04) sv++;
        end
        if (mv != 0 || first != 0) begin errors++; $display("FAIL idle_here_latency got=mv%0d/first%0d exp=mv0/first0", mv, first); end
        checks++;
        if (sv != 1 || dr != 6) begin errors++; $display("FAIL idle_here_door got=sv%0d/dr%0d exp=sv1/dr6", sv, dr); end
        checks++;
    endtask

    task automatic test_scan();
        int trace = 0;
        bit inj = 0, done = 0, dir_ok = 1;
        logic [7:0] calls;
        tick(8'h20, 1'b0);
        for (int i = 0; i < 120 && !done; i++) begin
            calls = (!inj && m_floor == 3 && m_mode == 1) ? 8'h02 : 8'h00;
            if (calls != 0) inj = 1;
            tick(calls, 1'b0);
            if (obs !== m_obs()) begin errors++; $display("FAIL scan t=%0t got=%h exp=%h", $time, obs, m_obs()); end
            checks++;
            if (served !== 8'h00) trace = trace * 10 + $clog2(int'(served));
            if (served === 8'h02 && dir_up !== 1'b0) dir_ok = 0;
            if (inj && m_mode == 0) done = 1;
        end
        if (!done) begin errors++; $display("FAIL scan_timeout got=busy exp=idle"); end
        checks++;
        if (trace != 51 || !dir_ok) begin errors++; $display("FAIL scan_order got=%0d dir_ok=%0d exp=51 dir_ok=1", trace, dir_ok); end
        checks++;
    endtask

    task automatic test_recall();
        int md = 0, dr = 0, strace = 0;
        bit inj = 0, done = 0;
        logic [7:0] calls;
        tick(8'h10, 1'b0);
        for (int i = 0; i < 60 && !done; i++) begin
            // Re-call latched in door cycle 3, so the re-pulse lands in cycle 4.
            calls = (!inj && md == 2) ? 8'h10 : 8'h00;
            if (calls != 0) inj = 1;
            tick(calls, 1'b0);
            if (obs !== m_obs()) begin errors++; $display("FAIL recall t=%0t got=%h exp=%h", $time, obs, m_obs()); end
            checks++;
            if (m_mode == 3) md++;
            if (door_open === 1'b1) dr++;
            if (served === 8'h10) strace = strace * 10 + md;
            if (md > 0 && m_mode == 0) done = 1;
        end
        if (!done) begin errors++; $display("FAIL recall_timeout got=busy exp=idle"); end
        checks++;
        if (dr != 9) begin errors++; $display("FAIL recall_door got=%0d exp=9", dr); end
        checks++;
        if (strace != 14) begin errors++; $display("FAIL recall_served got=%0d exp=14", strace); end
        checks++;
    endtask

`ifdef SVC_DOOR_HOLD_EN
    task automatic test_door_hold();
        int md = 0, dr = 0;
        bit done = 0, held_ok = 1;
        tick(8'h10, 1'b0);
        for (int i = 0; i < 60 && !done; i++) begin
            tick(8'h00, (md >= 1 && md <= 20));
            if (obs !== m_obs()) begin errors++; $display("FAIL door_hold t=%0t got=%h exp=%h", $time, obs, m_obs()); end
            checks++;
            if (m_mode == 3) md++;
            if (door_open === 1'b1) dr++;
            if (md >= 2 && md <= 21 && door_open !== 1'b1) held_ok = 0;
            if (md > 0 && m_mode == 0) done = 1;
        end
        hold_drv = 1'b0;
        if (!done || !held_ok || dr != 26) begin errors++; $display("FAIL door_hold_len got=%0d ok=%0d exp=26 ok=1", dr, held_ok); end
        checks++;
    endtask
`endif

    task automatic test_random();
        logic [7:0] calls;
        bit h;
        bit done = 0;
        for (int i = 0; i < 3000; i++) begin
            calls = ($urandom_range(0, 5) == 0) ? (8'd1 << $urandom_range(0, 7)) : 8'h00;
`ifdef SVC_DOOR_HOLD_EN
            h = ($urandom_range(0, 3) == 0);
`else
            h = 1'b0;
`endif
            tick(calls, h);
            if (obs !== m_obs()) begin errors++; $display("FAIL random t=%0t got=%h exp=%h", $time, obs, m_obs()); end
            checks++;
        end
        for (int i = 0; i < 400 && !done; i++) begin
            tick(8'h00, 1'b0);
            if (obs !== m_obs()) begin errors++; $display("FAIL random_drain t=%0t got=%h exp=%h", $time, obs, m_obs()); end
            checks++;
            if (m_mode == 0 && r == 0) done = 1;
        end
        if (!done || busy !== 1'b0) begin errors++; $display("FAIL random_timeout got=busy%0d exp=busy0", busy); end
        checks++;
    endtask

    initial begin
        clr_n = 1'b1;
        hold_drv = 1'b0;
        m_reset();
        test_reset();
        test_move_up();
        test_idle_here();
        test_scan();
        test_recall();
`ifdef SVC_DOOR_HOLD_EN
        test_door_hold();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
